psum_accumulator: RTL and testbench

PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

---
 rtl/psum_accumulator_pkg.sv | 27 ++
 rtl/psum_accumulator_if.sv | 36 +++
 rtl/psum_accumulator_requant.sv | 56 +++++
 rtl/psum_accumulator.sv | 137 +++++++++++++
 tb/tb_psum_accumulator.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/psum_accumulator_pkg.sv
// Shared definitions for the partial-sum accumulator: layer codes, reset levels,
// FSM state encoding and datapath widths.
package psum_accumulator_pkg;

    localparam int PSUM_W  = 19;
    localparam int OFMAP_W = 8;

    typedef enum logic {
        RST_ENABLE  = 1'b0,
        RST_DISABLE = 1'b1
    } rst_e;

    typedef enum logic [3:0] {
        LAYER1 = 4'd1,
        LAYER3 = 4'd3,
        LAYER4 = 4'd4,
        LAYER5 = 4'd5
    } layer_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        QUANT = 2'd2,
        HOLD  = 2'd3
    } state_e;

endpackage

// File: rtl/psum_accumulator_if.sv
// Beat input and requantised result bus between the PE group, the accumulator
// and the downstream ofmap consumer.
interface psum_accumulator_if #(
    parameter int SHIFT_W = 5
);
    import psum_accumulator_pkg::*;

    logic [3:0]                layer;
    logic                      wb_en;
    logic signed [PSUM_W-1:0]  groupsum_in1;
    logic signed [PSUM_W-1:0]  groupsum_in2;
    logic                      acc_first;
    logic                      acc_last;
    logic signed [OFMAP_W-1:0] bias1;
    logic signed [OFMAP_W-1:0] bias2;
    logic [SHIFT_W-1:0]        shift;
    logic                      ofmap_ready;
    logic signed [OFMAP_W-1:0] ofmap1;
    logic signed [OFMAP_W-1:0] ofmap2;
    logic                      ofmap_valid;
    logic                      busy;
    logic                      drop_err;

    modport master (
        output layer, wb_en, groupsum_in1, groupsum_in2, acc_first, acc_last,
               bias1, bias2, shift, ofmap_ready,
        input  ofmap1, ofmap2, ofmap_valid, busy, drop_err
    );

    modport slave (
        input  layer, wb_en, groupsum_in1, groupsum_in2, acc_first, acc_last,
               bias1, bias2, shift, ofmap_ready,
        output ofmap1, ofmap2, ofmap_valid, busy, drop_err
    );

endinterface

// File: rtl/psum_accumulator_requant.sv
// One lane of requantisation: add shifted bias and rounding, arithmetic shift,
// saturate to 8 bits. Define PSUM_RELU_EN to clamp to [0,127] instead of [-128,127].
module psum_requant
    import psum_accumulator_pkg::*;
#(
    parameter int ACC_W   = 24,
    parameter int SHIFT_W = 5
) (
    input  logic signed [ACC_W-1:0]   acc,
    input  logic signed [OFMAP_W-1:0] bias,
    input  logic [SHIFT_W-1:0]        shift,
    output logic signed [OFMAP_W-1:0] q
);

    // Wide enough for the accumulator or a fully shifted bias, plus carry headroom.
    localparam int BIAS_SPAN = OFMAP_W + (2 ** SHIFT_W);
    localparam int SUM_W     = ((ACC_W > BIAS_SPAN) ? ACC_W : BIAS_SPAN) + 2;

    localparam logic signed [SUM_W-1:0]   V_MAX = SUM_W'(127);
    localparam logic signed [SUM_W-1:0]   V_MIN = SUM_W'(-128);
    localparam logic signed [OFMAP_W-1:0] Q_MAX = 8'sd127;
    localparam logic signed [OFMAP_W-1:0] Q_MIN = 8'sh80;

    logic signed [SUM_W-1:0] acc_x;
    logic signed [SUM_W-1:0] bias_x;
    logic signed [SUM_W-1:0] rnd;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] v;

    always_comb begin
        acc_x  = SUM_W'(acc);
        bias_x = SUM_W'(bias) <<< shift;
        rnd    = (shift != '0) ? (SUM_W'(1) <<< (shift - SHIFT_W'(1))) : '0;
        sum    = acc_x + bias_x + rnd;
        v      = sum >>> shift;
    end

    // NOTE: q gets a default before the clamps so every path assigns it and no latch is inferred.
    always_comb begin
        q = v[OFMAP_W-1:0];
`ifdef PSUM_RELU_EN
        if (v < '0) begin
            q = '0;
        end else if (v > V_MAX) begin
            q = Q_MAX;
        end
`else
        if (v < V_MIN) begin
            q = Q_MIN;
        end else if (v > V_MAX) begin
            q = Q_MAX;
        end
`endif
    end

endmodule

// File: rtl/psum_accumulator.sv
// Two-lane partial-sum accumulator with per-pixel requantisation and a
// valid/ready result hold. PSUM_RELU_EN selects ReLU clamping in psum_requant.
module psum_accumulator
    import psum_accumulator_pkg::*;
#(
    parameter int ACC_W   = 24,
    parameter int SHIFT_W = 5
) (
    input logic               clk,
    input logic               rst,
    psum_accumulator_if.slave bus
);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_e                    state;
    layer_e                    layer_q;
    logic signed [ACC_W-1:0]   acc1;
    logic signed [ACC_W-1:0]   acc2;
    logic signed [OFMAP_W-1:0] bias1_q;
    logic signed [OFMAP_W-1:0] bias2_q;
    logic [SHIFT_W-1:0]        shift_q;
    logic signed [OFMAP_W-1:0] q1;
    logic signed [OFMAP_W-1:0] q2;
    logic signed [OFMAP_W-1:0] ofmap1;
    logic signed [OFMAP_W-1:0] ofmap2;
    logic                      ofmap_valid;
    logic                      busy;
    logic                      drop_err;
    layer_e                    layer_in;
    logic                      take_beat;

    // Saturating add of a sign-extended partial sum; overflow shows as a mismatch of the top two bits.
    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0]  a,
        input logic signed [PSUM_W-1:0] b
    );
        logic signed [ACC_W:0] s;
        s = (ACC_W+1)'(a) + (ACC_W+1)'(b);
        if (s[ACC_W] != s[ACC_W-1]) begin
            return s[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        return s[ACC_W-1:0];
    endfunction

    assign layer_in  = layer_e'(bus.layer);
    assign take_beat = bus.wb_en && (bus.acc_first || (state == ACCUM));

    psum_requant #(.ACC_W(ACC_W), .SHIFT_W(SHIFT_W)) u_requant1 (
        .acc   (acc1),
        .bias  (bias1_q),
        .shift (shift_q),
        .q     (q1)
    );

    psum_requant #(.ACC_W(ACC_W), .SHIFT_W(SHIFT_W)) u_requant2 (
        .acc   (acc2),
        .bias  (bias2_q),
        .shift (shift_q),
        .q     (q2)
    );

    // NOTE: all state here updates with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state       <= IDLE;
            layer_q     <= LAYER3;
            acc1        <= '0;
            acc2        <= '0;
            bias1_q     <= '0;
            bias2_q     <= '0;
            shift_q     <= '0;
            ofmap1      <= '0;
            ofmap2      <= '0;
            ofmap_valid <= 1'b0;
            busy        <= 1'b0;
            drop_err    <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (take_beat) begin
                        if (bus.acc_first) begin
                            layer_q <= layer_in;
                            acc1    <= ACC_W'(bus.groupsum_in1);
                            acc2    <= (layer_in == LAYER1) ? '0 : ACC_W'(bus.groupsum_in2);
                        end else begin
                            acc1 <= sat_add(acc1, bus.groupsum_in1);
                            if (layer_q != LAYER1) begin
                                acc2 <= sat_add(acc2, bus.groupsum_in2);
                            end
                        end
                        if (bus.acc_last) begin
                            bias1_q <= bus.bias1;
                            bias2_q <= bus.bias2;
                            shift_q <= bus.shift;
                            state   <= QUANT;
                        end else begin
                            state <= ACCUM;
                        end
                        busy <= 1'b1;
                    end
                end
                QUANT: begin
                    ofmap1      <= q1;
                    ofmap2      <= (layer_q == LAYER1) ? '0 : q2;
                    ofmap_valid <= 1'b1;
                    state       <= HOLD;
                    if (bus.wb_en) begin
                        drop_err <= 1'b1;
                    end
                end
                HOLD: begin
                    // Beats are never accepted here, even on the exit edge.
                    if (bus.wb_en) begin
                        drop_err <= 1'b1;
                    end
                    if (bus.ofmap_ready) begin
                        ofmap_valid <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ofmap1      = ofmap1;
    assign bus.ofmap2      = ofmap2;
    assign bus.ofmap_valid = ofmap_valid;
    assign bus.busy        = busy;
    assign bus.drop_err    = drop_err;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed-vector bench for psum_accumulator; expected values are hand computed
// and follow PSUM_RELU_EN when it is defined for the build.
module tb_psum_accumulator;
    import psum_accumulator_pkg::*;

`ifdef PSUM_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    psum_accumulator_if #(.SHIFT_W(5)) bus ();

    psum_accumulator #(.ACC_W(24), .SHIFT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic set_cfg(input int layer, input int b1, input int b2, input int sh);
        bus.layer = 4'(layer);
        bus.bias1 = 8'(b1);
        bus.bias2 = 8'(b2);
        bus.shift = 5'(sh);
    endtask

    // Called at a falling edge; presents one beat across the next rising edge.
    task automatic drive_beat(input logic first, input logic last, input int in1, input int in2);
        bus.wb_en        = 1'b1;
        bus.acc_first    = first;
        bus.acc_last     = last;
        bus.groupsum_in1 = 19'(in1);
        bus.groupsum_in2 = 19'(in2);
        @(negedge clk);
        bus.wb_en     = 1'b0;
        bus.acc_first = 1'b0;
        bus.acc_last  = 1'b0;
    endtask

    // Entered right after the last beat: QUANT cycle first, then the result.
    task automatic expect_result(input string tag, input int e1, input int e2);
        check({tag, "_quant_valid"}, bus.ofmap_valid, 0);
        check({tag, "_quant_busy"}, bus.busy, 1);
        @(negedge clk);
        check({tag, "_valid"}, bus.ofmap_valid, 1);
        check({tag, "_ofmap1"}, bus.ofmap1, e1);
        check({tag, "_ofmap2"}, bus.ofmap2, e2);
    endtask

    task automatic accept_result(input string tag);
        bus.ofmap_ready = 1'b1;
        @(negedge clk);
        bus.ofmap_ready = 1'b0;
        check({tag, "_done_valid"}, bus.ofmap_valid, 0);
        check({tag, "_done_busy"}, bus.busy, 0);
    endtask

    initial begin
        rst              = 1'b0;
        bus.wb_en        = 1'b0;
        bus.acc_first    = 1'b0;
        bus.acc_last     = 1'b0;
        bus.groupsum_in1 = '0;
        bus.groupsum_in2 = '0;
        bus.ofmap_ready  = 1'b0;
        set_cfg(3, 0, 0, 0);

        #3;
        check("rst_valid", bus.ofmap_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_drop", bus.drop_err, 0);
        check("rst_ofmap1", bus.ofmap1, 0);
        check("rst_ofmap2", bus.ofmap2, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single first+last beat, shift with rounding.
        set_cfg(3, 0, 0, 2);
        drive_beat(1'b1, 1'b1, 100, -50);
        expect_result("l3_single", 25, RELU ? 0 : -12);
        accept_result("l3_single");

        // Layer1 ignores lane 2 and saturates lane 1: (6000 + 16 + 8) >> 4 = 376.
        set_cfg(1, 1, 5, 4);
        drive_beat(1'b1, 1'b0, 1000, 999);
        drive_beat(1'b0, 1'b0, 2000, 999);
        drive_beat(1'b0, 1'b1, 3000, 999);
        expect_result("l1_sat", 127, 0);
        accept_result("l1_sat");

        // A beat without acc_first in IDLE is ignored.
        drive_beat(1'b0, 1'b0, 500, 500);
        check("idle_ignore_busy", bus.busy, 0);

        // Lane 1: (25 + 4 + 1) >> 1 = 15; lane 2: (-21 - 2 + 1) >> 1 = -11.
        set_cfg(4, 2, -1, 1);
        drive_beat(1'b1, 1'b0, 10, -7);
        drive_beat(1'b0, 1'b0, 20, -7);
        drive_beat(1'b0, 1'b1, -5, -7);
        expect_result("l4_multi", 15, RELU ? 0 : -11);
        accept_result("l4_multi");

        // acc_first during ACCUM restarts with the new data.
        set_cfg(5, 0, 0, 0);
        drive_beat(1'b1, 1'b0, 1000, 1000);
        drive_beat(1'b1, 1'b1, 4, -4);
        expect_result("restart", 4, RELU ? 0 : -4);
        accept_result("restart");

        // Hold with ready low, then a dropped beat, then exit coinciding with a new beat.
        set_cfg(4, 3, -3, 0);
        drive_beat(1'b1, 1'b1, 10, 20);
        expect_result("hold", 13, 17);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", bus.ofmap_valid, 1);
            check("hold_ofmap1", bus.ofmap1, 13);
            check("hold_ofmap2", bus.ofmap2, 17);
        end
        drive_beat(1'b1, 1'b0, 7, 7);
        check("drop_err", bus.drop_err, 1);
        check("drop_valid", bus.ofmap_valid, 1);
        check("drop_ofmap1", bus.ofmap1, 13);
        check("drop_ofmap2", bus.ofmap2, 17);
        bus.ofmap_ready = 1'b1;
        drive_beat(1'b1, 1'b1, 9, 9);
        bus.ofmap_ready = 1'b0;
        check("exit_beat_valid", bus.ofmap_valid, 0);
        check("exit_beat_busy", bus.busy, 0);
        check("exit_beat_drop", bus.drop_err, 1);
        @(negedge clk);
        check("exit_beat_no_quant", bus.ofmap_valid, 0);

        // Negative saturation.
        set_cfg(3, 0, 0, 0);
        drive_beat(1'b1, 1'b1, -100000, 100);
        expect_result("neg_sat", RELU ? 0 : -128, 100);
        accept_result("neg_sat");

        // Reset in the middle of an accumulation.
        set_cfg(3, 0, 0, 0);
        drive_beat(1'b1, 1'b0, 50, 50);
        drive_beat(1'b0, 1'b0, 50, 50);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_valid", bus.ofmap_valid, 0);
        check("midrst_drop", bus.drop_err, 0);
        check("midrst_ofmap2", bus.ofmap2, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("postrst_no_valid", bus.ofmap_valid, 0);
        end
        set_cfg(3, 0, 0, 3);
        drive_beat(1'b1, 1'b1, 8, 0);
        expect_result("postrst", 1, 0);
        accept_result("postrst");

        // 40 beats at the 19-bit limits saturate the accumulator rather than wrapping.
        set_cfg(3, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            drive_beat(i == 0, i == 39, 262143, -262144);
        end
        expect_result("acc_sat", 127, RELU ? 0 : -128);
        accept_result("acc_sat");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
